// File: rtl/frame_burst_reader.sv
// Fetches blocks of BURSTS controller reads while walking a circular frame buffer
// and publishes each finished block atomically through a shadow buffer.
module frame_burst_reader #(
  parameter int unsigned DATA_W     = 768,
  parameter int unsigned BURSTS     = 8,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned ADDR_STEP  = 16,
  parameter int unsigned FRAME_BASE = 0,
  parameter int unsigned FRAME_LAST = 393200
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ram_init,
  input  logic                       phy_init_done,
  input  logic                       new_frame,
  input  logic                       ask_data,
  input  logic                       abort,
  output logic [DATA_W*BURSTS-1:0]   read_data,
  output logic                       data_valid,
  output logic                       busy,
  output logic                       framing,
  output logic                       read_out,
  output logic [ADDR_W-1:0]          r_address_out,
  input  logic                       ready,
  input  logic [DATA_W-1:0]          read_data_in
);

  localparam int unsigned CNT_W = (BURSTS > 2) ? $clog2(BURSTS) : 1;
  localparam int unsigned BLK_W = DATA_W * BURSTS;
  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(FRAME_BASE);
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(FRAME_LAST);
  localparam logic [ADDR_W-1:0] STEP_A = ADDR_W'(ADDR_STEP);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BURSTS - 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    ADV,
    WAIT
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic                   framing_q, framing_d;
  logic                   busy_q, busy_d;
  logic                   read_out_q, read_out_d;
  logic                   data_valid_q, data_valid_d;
  logic                   abort_q, abort_d;
  logic [BLK_W-1:0]       read_data_q, read_data_d;
  // The final burst goes straight to read_data, so only BURSTS-1 slots are kept.
  logic [DATA_W-1:0]      shadow_q [BURSTS-1];
  logic [DATA_W-1:0]      shadow_d [BURSTS-1];

  logic en;
  assign en = ram_init & phy_init_done;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    framing_d    = framing_q;
    busy_d       = busy_q;
    read_out_d   = read_out_q;
    abort_d      = abort_q;
    read_data_d  = read_data_q;
    shadow_d     = shadow_q;
    data_valid_d = 1'b0;

    if (en) begin
      // An abort during a block is remembered so the block can drain cleanly.
      if (abort && (state_q != IDLE)) begin
        abort_d = 1'b1;
      end

      unique case (state_q)
        IDLE: begin
          if (abort) begin
            framing_d = 1'b0;
          end else if (framing_q && ask_data) begin
            read_out_d = 1'b1;
            busy_d     = 1'b1;
            cnt_d      = '0;
            state_d    = REQ;
          end else if (!framing_q && new_frame) begin
            addr_d     = BASE_A;
            framing_d  = 1'b1;
            read_out_d = 1'b1;
            busy_d     = 1'b1;
            cnt_d      = '0;
            state_d    = REQ;
          end
        end

        REQ: begin
          read_out_d = 1'b0;
          state_d    = ADV;
        end

        ADV: begin
          addr_d  = (addr_q == LAST_A) ? BASE_A : addr_q + STEP_A;
          state_d = WAIT;
        end

        WAIT: begin
          if (ready) begin
            if (cnt_q == CNT_LAST) begin
              for (int i = 0; i < int'(BURSTS) - 1; i++) begin
                read_data_d[BLK_W-1-i*DATA_W -: DATA_W] = shadow_q[i];
              end
              read_data_d[DATA_W-1:0] = read_data_in;
              data_valid_d = 1'b1;
              busy_d       = 1'b0;
              state_d      = IDLE;
              if (abort_d) begin
                framing_d = 1'b0;
              end
              abort_d = 1'b0;
            end else begin
              shadow_d[cnt_q] = read_data_in;
              cnt_d           = cnt_q + 1'b1;
              read_out_d      = 1'b1;
              state_d         = REQ;
            end
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      addr_q       <= BASE_A;
      framing_q    <= 1'b0;
      busy_q       <= 1'b0;
      read_out_q   <= 1'b0;
      data_valid_q <= 1'b0;
      abort_q      <= 1'b0;
      read_data_q  <= '0;
      shadow_q     <= '{default: '0};
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      framing_q    <= framing_d;
      busy_q       <= busy_d;
      read_out_q   <= read_out_d;
      data_valid_q <= data_valid_d;
      abort_q      <= abort_d;
      read_data_q  <= read_data_d;
      shadow_q     <= shadow_d;
    end
  end

  assign read_data     = read_data_q;
  assign data_valid    = data_valid_q;
  assign busy          = busy_q;
  assign framing       = framing_q;
  assign read_out      = read_out_q;
  assign r_address_out = addr_q;

endmodule

// File: tb/tb_frame_burst_reader.sv
// Randomised bench for frame_burst_reader: a memory responder plus a block-level
// reference model (address walk, block contents, capture count) checks the DUT.
module tb_frame_burst_reader;

  localparam int DW   = 768;
  localparam int NB   = 8;
  localparam int BW   = DW * NB;
  localparam int STEP = 16;
  localparam int BASE = 0;
  // A short frame keeps the wrap reachable within a small cycle budget.
  localparam int LAST = 320;

  logic          clk;
  logic          reset;
  logic          ram_init;
  logic          phy_init_done;
  logic          new_frame;
  logic          ask_data;
  logic          abort;
  logic [BW-1:0] read_data;
  logic          data_valid;
  logic          busy;
  logic          framing;
  logic          read_out;
  logic [31:0]   r_address_out;
  logic          ready;
  logic [DW-1:0] read_data_in;

  frame_burst_reader #(
    .DATA_W(DW), .BURSTS(NB), .ADDR_W(32), .ADDR_STEP(STEP),
    .FRAME_BASE(BASE), .FRAME_LAST(LAST)
  ) dut (
    .clk(clk), .reset(reset), .ram_init(ram_init), .phy_init_done(phy_init_done),
    .new_frame(new_frame), .ask_data(ask_data), .abort(abort),
    .read_data(read_data), .data_valid(data_valid), .busy(busy), .framing(framing),
    .read_out(read_out), .r_address_out(r_address_out),
    .ready(ready), .read_data_in(read_data_in)
  );

  int            n_chk = 0;
  int            n_err = 0;
  bit            mon_on = 0;
  bit            resp_on = 0;
  int            maxdly = 0;
  int            nready = 0;
  int            cyc = 0;
  logic [DW-1:0] salt = '0;
  logic [31:0]   exp_addr = BASE;
  logic [BW-1:0] model_rd = '0;
  logic [31:0]   blk_addrs [$];
  logic [31:0]   pend_a [$];
  int            pend_t [$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input logic [31:0] a);
    return DW'(a / STEP) ^ salt;
  endfunction

  function automatic logic [DW-1:0] rd_slice(input int k);
    return read_data[BW-1-k*DW -: DW];
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_dv(input int budget);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!data_valid && k < budget);
    chk("dv_timeout", DW'(data_valid), DW'(1));
  endtask

  task automatic wait_ro(output logic [31:0] a, input int budget);
    int k = 0;
    while (!read_out && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("ro_timeout", DW'(read_out), DW'(1));
    a = r_address_out;
  endtask

  task automatic pulse_ask();
    ask_data = 1'b1;
    @(negedge clk);
    ask_data = 1'b0;
  endtask

  // Counts read_out pulses until the n-th one is seen (current cycle included).
  task automatic wait_nth_ro(input int n, input string tag);
    int seen = 0;
    int k = 0;
    while (k < 600) begin
      if (read_out) seen++;
      if (seen == n) break;
      @(negedge clk);
      k++;
    end
    chk(tag, DW'(seen), DW'(n));
  endtask

  // Captures the controller actually delivers: ready while enabled.
  initial forever begin
    @(posedge clk);
    if (ready && ram_init && phy_init_done) nready++;
  end

  // Monitor/model and memory responder, all at the falling edge.
  initial forever begin
    @(negedge clk);
    cyc++;
    if (mon_on) begin
      if (read_out) begin
        chk("rd_addr", DW'(r_address_out), DW'(exp_addr));
        blk_addrs.push_back(r_address_out);
        exp_addr = (exp_addr == LAST) ? BASE : exp_addr + STEP;
      end
      if (data_valid) begin
        chk("captures", DW'(nready), DW'(NB));
        nready = 0;
        chk("blk_addrs", DW'(blk_addrs.size()), DW'(NB));
        if (blk_addrs.size() >= NB) begin
          for (int k = 0; k < NB; k++) model_rd[BW-1-k*DW -: DW] = pat(blk_addrs.pop_front());
        end
      end
      for (int k = 0; k < NB; k++) chk("read_data", rd_slice(k), model_rd[BW-1-k*DW -: DW]);
    end
    if (resp_on) begin
      ready = 1'b0;
      if (read_out) begin
        pend_a.push_back(r_address_out);
        pend_t.push_back(cyc + 2 + int'($urandom_range(0, maxdly)));
      end
      if (pend_a.size() > 0 && cyc >= pend_t[0]) begin
        ready        = 1'b1;
        read_data_in = pat(pend_a.pop_front());
        void'(pend_t.pop_front());
      end
    end
  end

  initial begin
    logic [31:0] a;
    int k;
    reset = 1'b1; ram_init = 1'b1; phy_init_done = 1'b1;
    new_frame = 1'b0; ask_data = 1'b0; abort = 1'b0;
    ready = 1'b0; read_data_in = '0;
    tick(3);
    chk("rst_read_out", DW'(read_out), DW'(0));
    chk("rst_addr", DW'(r_address_out), DW'(BASE));
    chk("rst_busy", DW'(busy), DW'(0));
    chk("rst_framing", DW'(framing), DW'(0));
    chk("rst_dv", DW'(data_valid), DW'(0));
    chk("rst_rd_top", rd_slice(0), '0);
    reset = 1'b0;
    mon_on = 1'b1;
    resp_on = 1'b1;

    // First block after new_frame, ready effectively always on: data = burst index.
    maxdly = 0;
    exp_addr = BASE;
    new_frame = 1'b1;
    @(negedge clk);
    new_frame = 1'b0;
    chk("t1_busy", DW'(busy), DW'(1));
    chk("t1_read_out", DW'(read_out), DW'(1));
    chk("t1_framing", DW'(framing), DW'(1));
    k = 0;
    while (!data_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("t1_dv_edge", DW'(k), DW'(3 * NB));
    chk("t1_busy_done", DW'(busy), DW'(0));
    chk("t1_addr_next", DW'(r_address_out), DW'(128));
    chk("t1_burst0", rd_slice(0), DW'(0));
    chk("t1_burst3", rd_slice(3), DW'(3));
    chk("t1_burst7", rd_slice(7), DW'(7));
    tick(1);
    chk("t1_dv_strobe", DW'(data_valid), DW'(0));

    // Randomised ready delays across several address wraps.
    maxdly = 20;
    for (int b = 0; b < 8; b++) begin
      for (int i = 0; i < DW / 32; i++) salt[i*32 +: 32] = $urandom();
      tick(int'($urandom_range(0, 3)));
      pulse_ask();
      wait_dv(NB * 30);
    end

    // Abort while burst 3 is in flight: block completes, framing then drops.
    pulse_ask();
    wait_nth_ro(4, "t3_burst3");
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_dv(NB * 30);
    chk("t3_framing_off", DW'(framing), DW'(0));
    tick(1);
    ask_data = 1'b1;
    k = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      ask_data = 1'b0;
      if (read_out) k++;
    end
    chk("t3_no_read", DW'(k), DW'(0));
    chk("t3_idle_busy", DW'(busy), DW'(0));
    exp_addr = BASE;
    new_frame = 1'b1;
    @(negedge clk);
    new_frame = 1'b0;
    chk("t3_restart_addr", DW'(r_address_out), DW'(BASE));
    wait_dv(NB * 30);
    chk("t3_framing_on", DW'(framing), DW'(1));

    // PHY drops out while waiting on burst 2; a ready in the gap must be ignored.
    tick(2);
    resp_on = 1'b0;
    ready = 1'b0;
    pulse_ask();
    for (int b = 0; b < NB; b++) begin
      wait_ro(a, 40);
      tick(2);
      if (b == 2) begin
        phy_init_done = 1'b0;
        for (int g = 0; g < 10; g++) begin
          ready = (g == 4);
          read_data_in = ~pat(a);
          @(negedge clk);
          chk("t4_gap_dv", DW'(data_valid), DW'(0));
          chk("t4_gap_busy", DW'(busy), DW'(1));
          chk("t4_gap_addr", DW'(r_address_out), DW'(exp_addr));
        end
        phy_init_done = 1'b1;
      end
      ready = 1'b1;
      read_data_in = pat(a);
      @(negedge clk);
      ready = 1'b0;
    end
    chk("t4_dv", DW'(data_valid), DW'(1));
    resp_on = 1'b1;

    // Reset during ADV of burst 5; the late ready must not disturb anything.
    maxdly = 0;
    tick(2);
    pulse_ask();
    wait_nth_ro(6, "t5_burst5");
    @(negedge clk);
    mon_on = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t5_read_out", DW'(read_out), DW'(0));
    chk("t5_addr", DW'(r_address_out), DW'(BASE));
    chk("t5_busy", DW'(busy), DW'(0));
    chk("t5_framing", DW'(framing), DW'(0));
    chk("t5_dv", DW'(data_valid), DW'(0));
    tick(5);
    chk("t5_late_busy", DW'(busy), DW'(0));
    chk("t5_late_dv", DW'(data_valid), DW'(0));
    chk("t5_late_addr", DW'(r_address_out), DW'(BASE));
    chk("t5_pend_empty", DW'(pend_a.size()), DW'(0));
    for (int j = 0; j < NB; j++) chk("t5_rd_zero", rd_slice(j), '0);

    // Back to normal operation after the reset.
    nready = 0;
    blk_addrs.delete();
    model_rd = '0;
    mon_on = 1'b1;
    exp_addr = BASE;
    maxdly = 5;
    new_frame = 1'b1;
    @(negedge clk);
    new_frame = 1'b0;
    wait_dv(NB * 30);
    tick(3);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
